serial_compare_ctrl: RTL

Sequential magnitude-compare controller. Compares two WIDTH-bit unsigned operands, MSB-first, two bits per cycle. Each cycle it time-shares a single instance of the team's 2-bit greater_than comparator plus a 2-bit equality check. It gives wide compares a small, fixed-area datapath, with a start/done handshake towards the sequencing logic.

---
 rtl/serial_compare_ctrl_pkg.sv | 21 ++
 rtl/serial_compare_ctrl_greater_than.sv | 10 +
 rtl/serial_compare_ctrl.sv | 121 ++++++++++++
 3 files changed

// File: rtl/serial_compare_ctrl_pkg.sv
// Shared definitions for the serial magnitude-compare controller:
// FSM state encoding, one-hot result codes and slice-index sizing.
package serial_compare_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_SCAN = 2'b01,
    ST_DONE = 2'b10,
    ST_RSVD = 2'b11
  } state_e;

  // Result codes ordered {gt, eq, lt}
  localparam logic [2:0] RES_GT = 3'b100;
  localparam logic [2:0] RES_EQ = 3'b010;
  localparam logic [2:0] RES_LT = 3'b001;

  function automatic int unsigned idx_width(input int unsigned nslice);
    return (nslice > 1) ? $clog2(nslice) : 1;
  endfunction

endpackage

// File: rtl/serial_compare_ctrl_greater_than.sv
// 2-bit unsigned greater-than comparator, time-shared across operand slices.
module serial_compare_ctrl_greater_than (
  input  logic [1:0] a_i,
  input  logic [1:0] b_i,
  output logic       gt_c_o
);

  assign gt_c_o = (a_i > b_i);

endmodule

// File: rtl/serial_compare_ctrl.sv
// MSB-first serial magnitude compare, two bits per cycle, start/done handshake.
// Define EARLY_EXIT_EN to finish on the first differing slice instead of a fixed latency.
module serial_compare_ctrl
  import serial_compare_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                start,
  input  logic [WIDTH-1:0]                    a,
  input  logic [WIDTH-1:0]                    b,
  output logic                                busy,
  output logic                                done,
  output logic                                a_gt_b,
  output logic                                a_eq_b,
  output logic                                a_lt_b,
  output logic [idx_width(WIDTH/2)-1:0]       slice_idx
);

  localparam int unsigned NSLICE = WIDTH / 2;
  localparam int unsigned IDX_W  = idx_width(NSLICE);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

  state_e             state_q;
  logic [WIDTH-1:0]   a_q, b_q;
  logic [IDX_W-1:0]   idx_q;
  logic               dec_q, gt_q;
  logic               busy_q, done_q;
  logic [2:0]         res_q;

  logic [1:0]         a_sl_c, b_sl_c;
  logic               gt_c, eq_c, exit_c;

  // Select the slice under examination from the latched operands
  always_comb begin
    a_sl_c = '0;
    b_sl_c = '0;
    for (int unsigned k = 0; k < NSLICE; k++) begin
      if (idx_q == IDX_W'(k)) begin
        a_sl_c = a_q[2*k +: 2];
        b_sl_c = b_q[2*k +: 2];
      end
    end
  end

  serial_compare_ctrl_greater_than u_gt (
    .a_i    (a_sl_c),
    .b_i    (b_sl_c),
    .gt_c_o (gt_c)
  );

  assign eq_c = (a_sl_c == b_sl_c);

  always_comb begin
    exit_c = (idx_q == '0);
`ifdef EARLY_EXIT_EN
    if (!dec_q && !eq_c) exit_c = 1'b1;
`endif
  end

  // Control FSM; verdict is sticky once the first differing slice is seen
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      idx_q   <= LAST_IDX;
      dec_q   <= 1'b0;
      gt_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      res_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            res_q   <= '0;
            idx_q   <= LAST_IDX;
            dec_q   <= 1'b0;
            gt_q    <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (!dec_q && !eq_c) begin
            dec_q <= 1'b1;
            gt_q  <= gt_c;
          end
          if (exit_c) begin
            state_q <= ST_DONE;
          end else begin
            idx_q <= idx_q - IDX_W'(1);
          end
        end
        ST_DONE: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          res_q   <= dec_q ? (gt_q ? RES_GT : RES_LT) : RES_EQ;
          state_q <= ST_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign a_gt_b    = res_q[2];
  assign a_eq_b    = res_q[1];
  assign a_lt_b    = res_q[0];
  assign slice_idx = idx_q;

endmodule
